ppt_fire_sequencer: RTL and testbench

PPT_FIRE_SEQUENCER -- requirements
Module: ppt_fire_sequencer

---
 rtl/ppt_fire_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ppt_fire_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ppt_fire_sequencer.sv
// ppt_fire_sequencer: pulsed plasma thruster fire sequencer.
// Fires `count` shots, each `period` ticks long with the trigger high for the
// first `width` ticks. A tick is one clk cycle in every 2^(clk_div+1).
// Optional build macro: PPT_ABORT_EN -- when defined, dropping run_ppt during
// FIRE or GAP aborts the sequence back to IDLE; otherwise the sequence always
// runs to DONE once started.
module ppt_fire_sequencer (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  clk_div,
  input  logic [15:0] period,
  input  logic [15:0] width,
  input  logic [15:0] count,
  input  logic        run_ppt,
  output logic        fire,
  output logic [15:0] count_done,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Configuration captured at start; inputs are ignored outside IDLE.
  logic [4:0]  div_q, div_d;
  logic [15:0] period_q, period_d;   // already clamped to >= 1
  logic [15:0] width_q, width_d;     // already clamped to <= period_q
  logic [15:0] count_q, count_d;

  logic [31:0] pre_q, pre_d;         // free-running prescaler, cleared on start
  logic [15:0] tick_q, tick_d;       // ticks elapsed in the current shot

  logic        fire_d, done_d, busy_d;
  logic [15:0] count_done_d;

  // Clamped view of the live inputs, used only on the start edge.
  logic [15:0] period_in_eff;
  logic [15:0] width_in_eff;
  assign period_in_eff = (period == 16'd0) ? 16'd1 : period;
  assign width_in_eff  = (width > period_in_eff) ? period_in_eff : width;

  // A tick fires when the low (div+1) prescaler bits are all ones; a shift of
  // 32 (div = 31) yields an all-ones mask.
  logic [31:0] pre_mask;
  logic        tick;
  assign pre_mask = ~(32'hFFFF_FFFF << ({1'b0, div_q} + 6'd1));
  assign tick     = (pre_q & pre_mask) == pre_mask;

  logic [15:0] tick_inc;
  logic [15:0] count_done_inc;
  assign tick_inc       = tick_q + 16'd1;
  assign count_done_inc = count_done + 16'd1;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned
    // (which would infer a latch).
    state_d      = state_q;
    div_d        = div_q;
    period_d     = period_q;
    width_d      = width_q;
    count_d      = count_q;
    pre_d        = pre_q;
    tick_d       = tick_q;
    fire_d       = fire;
    count_done_d = count_done;

    case (state_q)
      IDLE: begin
        if (run_ppt) begin
          div_d        = clk_div;
          period_d     = period_in_eff;
          width_d      = width_in_eff;
          count_d      = count;
          count_done_d = 16'd0;
          pre_d        = 32'd0;
          tick_d       = 16'd0;
          if (count == 16'd0) begin
            state_d = DONE;
            fire_d  = 1'b0;
          end else if (width_in_eff != 16'd0) begin
            state_d = FIRE;
            fire_d  = 1'b1;
          end else begin
            state_d = GAP;
            fire_d  = 1'b0;
          end
        end
      end

      FIRE, GAP: begin
        pre_d = pre_q + 32'd1;
        if (tick) begin
          if (tick_inc == period_q) begin
            // Shot ends; either finish or begin the next shot.
            tick_d       = 16'd0;
            count_done_d = count_done_inc;
            if (count_done_inc == count_q) begin
              state_d = DONE;
              fire_d  = 1'b0;
            end else if (width_q != 16'd0) begin
              state_d = FIRE;
              fire_d  = 1'b1;
            end else begin
              state_d = GAP;
              fire_d  = 1'b0;
            end
          end else begin
            tick_d = tick_inc;
            // Only reachable when width < period, since width == period is
            // caught by the shot-end branch above.
            if (state_q == FIRE && tick_inc == width_q) begin
              state_d = GAP;
              fire_d  = 1'b0;
            end
          end
        end
`ifdef PPT_ABORT_EN
        // Abort overrides any tick activity; count_done keeps its value.
        if (!run_ppt) begin
          state_d      = IDLE;
          fire_d       = 1'b0;
          count_done_d = count_done;
        end
`endif
      end

      DONE: begin
        if (!run_ppt) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        fire_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == FIRE) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: reset is asynchronous so fire drops the instant rstn goes low,
    // without waiting for a clock edge.
    if (!rstn) begin
      state_q    <= IDLE;
      div_q      <= 5'd0;
      period_q   <= 16'd1;
      width_q    <= 16'd0;
      count_q    <= 16'd0;
      pre_q      <= 32'd0;
      tick_q     <= 16'd0;
      fire       <= 1'b0;
      count_done <= 16'd0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge.
      state_q    <= state_d;
      div_q      <= div_d;
      period_q   <= period_d;
      width_q    <= width_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      fire       <= fire_d;
      count_done <= count_done_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_ppt_fire_sequencer.sv
// tb_ppt_fire_sequencer: self-checking bench for ppt_fire_sequencer.
// Expected {fire, busy, done, count_done} per clock edge is computed from a
// closed-form timing model, queued when a sequence is launched, and popped
// as the DUT produces each cycle's outputs.
module tb_ppt_fire_sequencer;

`ifdef PPT_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam int NEVER = 1 << 30;

  logic        clk;
  logic        rstn;
  logic [4:0]  clk_div;
  logic [15:0] period;
  logic [15:0] width;
  logic [15:0] count;
  logic        run_ppt;
  logic        fire;
  logic [15:0] count_done;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_q[$];

  ppt_fire_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
    .fire       (fire),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after edge n of a sequence started on edge 0. run_ppt is
  // seen low from edge drop+1 onward.
  function automatic logic [18:0] ref_out(input int div, input int p, input int w,
                                          input int shots, input int n, input int drop);
    int t, pe, we, len, total, leave, s, ph;
    logic f;
    t     = 1 << (div + 1);
    pe    = (p == 0) ? 1 : p;
    we    = (w > pe) ? pe : w;
    len   = pe * t;
    total = shots * len;
    if (ABORT_EN && drop < total && n > drop)
      return {1'b0, 1'b0, 1'b0, 16'(drop / len)};
    if (n < total) begin
      s  = n / len;
      ph = n % len;
      f  = (we == pe) || (ph < we * t);
      return {f, 1'b1, 1'b0, 16'(s)};
    end
    leave = ((total > drop) ? total : drop) + 1;
    if (n < leave) return {1'b0, 1'b0, 1'b1, 16'(shots)};
    return {1'b0, 1'b0, 1'b0, 16'(shots)};
  endfunction

  function automatic logic [18:0] observed();
    return {fire, busy, done, count_done};
  endfunction

  // Launch a sequence, queue its expected trace, then compare each edge.
  // Inputs are scrambled after the start edge; the DUT must ignore them.
  task automatic run_seq(input string tag, input int div, input int p, input int w,
                         input int shots, input int ncyc, input int drop);
    logic [18:0] e;
    clk_div = 5'(div);
    period  = 16'(p);
    width   = 16'(w);
    count   = 16'(shots);
    run_ppt = 1'b1;
    for (int n = 0; n < ncyc; n++) exp_q.push_back(ref_out(div, p, w, shots, n, drop));
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, n), 32'(observed()), 32'(e));
      if (n == 0) begin
        clk_div = 5'($urandom);
        period  = 16'($urandom);
        width   = 16'($urandom);
        count   = 16'($urandom);
      end
      if (n == drop) run_ppt = 1'b0;
    end
  endtask

  initial begin
    logic [18:0] e;
    rstn    = 1'b0;
    run_ppt = 1'b0;
    clk_div = 5'd0;
    period  = 16'd0;
    width   = 16'd0;
    count   = 16'd0;

    #2;
    exp_q.push_back(19'd0);
    e = exp_q.pop_front();
    check("reset_state", 32'(observed()), 32'(e));
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    // 3 pulses, fire high 2 of every 8 clk, done after 24 clk.
    run_seq("basic", 0, 4, 1, 3, 27, 25);
    // count = 0: straight to DONE, no fire.
    run_seq("zero_count", 0, 4, 1, 0, 3, 1);
    // width > period: fire held continuously for 8 clk.
    run_seq("cont", 0, 2, 5, 2, 11, 9);
    // Larger prescaler.
    run_seq("div2", 2, 3, 2, 2, 51, 49);
    // width = 0: shots elapse with fire never high.
    run_seq("width0", 0, 3, 0, 1, 9, 7);
    // period = 0 is treated as 1, so width clamps to 1 and fire is continuous.
    run_seq("period0", 1, 0, 3, 2, 11, 9);
    // run_ppt dropped during the second shot.
    run_seq("abort", 0, 4, 1, 3, 30, 10);

    // Asynchronous reset while firing, then restart on the first edge.
    clk_div = 5'd0;
    period  = 16'd4;
    width   = 16'd2;
    count   = 16'd2;
    run_ppt = 1'b1;
    exp_q.push_back(ref_out(0, 4, 2, 2, 0, NEVER));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rst_pre_fire", 32'(observed()), 32'(e));
    #2 rstn = 1'b0;
    exp_q.push_back(19'd0);
    #1;
    e = exp_q.pop_front();
    check("rst_async", 32'(observed()), 32'(e));
    #2 rstn = 1'b1;
    run_seq("after_rst", 0, 4, 2, 2, 19, 17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
